// File: rtl/key_array_debounce.sv
// Per-key synchronise + debounce with press/release pulses and a lowest-index key encoder.
// Optional macro KEY_AUTO_REPEAT_EN adds a per-key auto-repeat timer on key_press.
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int KEY_ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic RELEASED = (KEY_ACTIVE_LOW != 0);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             pressed;
  logic             rep_fire;

  assign pressed = sync_q[1] ^ RELEASED;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_rate_q, rep_rate_d;

  // Timer only runs while the key stays held; a new press or any release restarts it.
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    rep_rate_d = rep_rate_q;
    rep_fire   = 1'b0;
    if (!(level_q && level_d)) begin
      rep_cnt_d  = '0;
      rep_rate_d = 1'b0;
    end else if (rep_cnt_q == (rep_rate_q ? REP_W'(REPEAT_RATE_CYCLES - 1)
                                          : REP_W'(REPEAT_DELAY_CYCLES - 1))) begin
      rep_fire   = 1'b1;
      rep_cnt_d  = '0;
      rep_rate_d = 1'b1;
    end else begin
      rep_cnt_d  = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q  <= '0;
      rep_rate_q <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_rate_q <= rep_rate_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    sync_d  = {sync_q[0], key_in};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = pressed;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = (level_d & ~level_q) | rep_fire;
    rel_d   = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {2{RELEASED}};
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
endmodule

module key_array_debounce #(
  parameter int NUM_KEYS            = 4,
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int KEY_ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000,
  localparam int CODE_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid
);
  if (NUM_KEYS < 1 || NUM_KEYS > 16 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_param
    $error("key_array_debounce: parameter out of range");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW     (KEY_ACTIVE_LOW),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .key_in(key_in[i]),
      .level (key_level[i]),
      .press (key_press[i]),
      .rel   (key_release[i])
    );
  end

  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;

  // Scan downward so the lowest pressed index wins.
  always_comb begin
    code_d  = '0;
    valid_d = |key_level;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_level[i]) code_d = CODE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
endmodule

// File: tb/tb_key_array_debounce.sv
// Directed bench for key_array_debounce: NUM_KEYS=4, DEBOUNCE_CYCLES=8, active-low pins.
module tb_key_array_debounce;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_level, key_press, key_release;
  logic [1:0] key_code;
  logic       key_valid;

  int n_cmp = 0;
  int n_err = 0;
  int overlap = 0;

  key_array_debounce #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .KEY_ACTIVE_LOW(1),
    .REPEAT_DELAY_CYCLES(20), .REPEAT_RATE_CYCLES(6)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (|(key_press & key_release)) overlap++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_rep, first_rep, flag;
    rst = 1'b1;
    key_in = 4'hF;
    repeat (3) tick();
    chk("rst_level", key_level, 0);
    chk("rst_press", key_press, 0);
    chk("rst_release", key_release, 0);
    chk("rst_code", key_code, 0);
    chk("rst_valid", key_valid, 0);
    rst = 1'b0;
    repeat (12) tick();
    chk("idle_level", key_level, 0);

    // Clean press of key 1, then a long hold.
    n_rep = 0; first_rep = 0;
    key_in[1] = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 9) begin
        chk("press_lvl_c9", key_level, 4'b0000);
        chk("press_pls_c9", key_press, 4'b0000);
      end
      if (k == 10) begin
        chk("press_lvl_c10", key_level, 4'b0010);
        chk("press_pls_c10", key_press, 4'b0010);
        chk("press_valid_c10", key_valid, 0);
      end
      if (k == 11) begin
        chk("press_pls_c11", key_press, 4'b0000);
        chk("press_code_c11", key_code, 1);
        chk("press_valid_c11", key_valid, 1);
      end
      if (k >= 12 && key_press[1]) begin
        n_rep++;
        if (first_rep == 0) first_rep = k;
      end
    end
`ifdef KEY_AUTO_REPEAT_EN
    chk("repeat_count", n_rep, 4);
    chk("repeat_first", first_rep, 30);
`else
    chk("hold_no_repeat", n_rep, 0);
`endif
    chk("hold_level", key_level, 4'b0010);

    // Release key 1.
    key_in[1] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) begin
        chk("rel_lvl_c9", key_level, 4'b0010);
        chk("rel_pls_c9", key_release, 4'b0000);
      end
      if (k == 10) begin
        chk("rel_lvl_c10", key_level, 4'b0000);
        chk("rel_pls_c10", key_release, 4'b0010);
        chk("rel_press_c10", key_press, 4'b0000);
        chk("rel_valid_c10", key_valid, 1);
      end
      if (k == 11) begin
        chk("rel_pls_c11", key_release, 4'b0000);
        chk("rel_valid_c11", key_valid, 0);
        chk("rel_code_c11", key_code, 0);
      end
    end

    // Bounce on key 0: low for 5 cycles only.
    flag = 0;
    key_in[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5) key_in[0] = 1'b1;
      if (key_level[0] || key_press[0] || key_valid) flag = 1;
    end
    chk("bounce_quiet", flag, 0);

    // Simultaneous press of keys 3 and 2.
    key_in = 4'b0011;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) begin
        chk("simul_press_c10", key_press, 4'b1100);
        chk("simul_lvl_c10", key_level, 4'b1100);
      end
      if (k == 11) begin
        chk("simul_code_c11", key_code, 2);
        chk("simul_valid_c11", key_valid, 1);
      end
    end
    key_in = 4'hF;
    repeat (12) tick();
    chk("simul_rel_level", key_level, 0);
    chk("simul_rel_valid", key_valid, 0);

    // Reset mid-count with key 0 held through reset release.
    flag = 0;
    key_in[0] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        rst = 1'b0;
        chk("rstmid_lvl_c6", key_level, 0);
      end
      if (k < 16 && key_press != 4'b0000) flag = 1;
      if (k == 16) begin
        chk("rstmid_press_c16", key_press, 4'b0001);
        chk("rstmid_lvl_c16", key_level, 4'b0001);
      end
      if (k == 17) chk("rstmid_code_c17", {key_valid, key_code}, 3'b100);
    end
    chk("rstmid_no_early", flag, 0);
    key_in = 4'hF;
    repeat (12) tick();

    chk("no_press_release_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/key_array_debounce.md
KEY_ARRAY_DEBOUNCE -- requirements
Module: key_array_debounce

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_KEYS, default 4: number of independent key channels, range 1..16.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000: stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
REQ-004 Parameter KEY_ACTIVE_LOW, default 1: 1 means the pin reads 0 when pressed; 0 means the pin reads 1 when pressed.
REQ-005 Parameter REPEAT_DELAY_CYCLES, default 25000000: hold time before the first auto-repeat; minimum 1.
REQ-006 Parameter REPEAT_RATE_CYCLES, default 5000000: interval between auto-repeats; minimum 1.
REQ-007 Port clk, input, 1: system clock.
REQ-008 Port rst, input, 1: synchronous reset, active-high.
REQ-009 Port key_in, input, NUM_KEYS: raw asynchronous key pins.
REQ-010 Port key_level, output, NUM_KEYS: debounced pressed state, 1 = pressed.
REQ-011 Port key_press, output, NUM_KEYS: one-cycle pulse per accepted press (and per repeat).
REQ-012 Port key_release, output, NUM_KEYS: one-cycle pulse per accepted release.
REQ-013 Port key_code, output, clog2(NUM_KEYS) (min 1): index of the lowest-numbered pressed key.
REQ-014 Port key_valid, output, 1: high when any key_level bit is 1.

Function
REQ-015 Each key_in bit SHALL pass through a 2-flop synchronizer and then be normalised to pressed=1 according to KEY_ACTIVE_LOW.
REQ-016 Each channel SHALL own a counter of width clog2(DEBOUNCE_CYCLES+1); channels SHALL be fully independent.
REQ-017 Counter rule, per cycle:
  - synced value == key_level: counter <= 0.
  - else, counter == DEBOUNCE_CYCLES-1: key_level <= synced value; counter <= 0.
  - else: counter increments.
REQ-018 A clean pin edge at cycle t SHALL change key_level at cycle t+2+DEBOUNCE_CYCLES.
REQ-019 Any pin glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation SHALL produce no output change.
REQ-020 key_press[i] SHALL pulse high for exactly the cycle in which key_level[i] rises.
REQ-021 key_release[i] SHALL pulse high for exactly the cycle in which key_level[i] falls.
REQ-022 key_code and key_valid SHALL be registered one cycle after key_level.
  - key_code = lowest index i with key_level[i]=1, else 0.
  - Simultaneous presses SHALL resolve to the lowest index.
REQ-023 key_press and key_release SHALL never be high together on the same channel.

Reset
REQ-024 While rst=1, all of the following SHALL be forced on the next clk edge:
  - synchronizer flops SHALL be set to the released level;
  - counters and repeat timers SHALL be set to 0;
  - key_level, key_press, key_release, key_code and key_valid SHALL be set to 0.
REQ-025 Reset asserted mid-count SHALL discard the count and emit no pulse.
REQ-026 A key held through reset release SHALL be reported as a new press 2+DEBOUNCE_CYCLES cycles after rst falls.

Configuration
REQ-027 Macro KEY_AUTO_REPEAT_EN, when defined, SHALL compile in one auto-repeat timer per channel.
  - With the initial key_press pulse at cycle P and the key still held, repeat pulses SHALL occur at P+REPEAT_DELAY_CYCLES, then every REPEAT_RATE_CYCLES.
  - Release SHALL clear the timer immediately.
  - key_level SHALL be unaffected by repeats.
REQ-028 When KEY_AUTO_REPEAT_EN is undefined:
  - no repeat logic SHALL be synthesised;
  - key_press SHALL pulse once per accepted press;
  - the REPEAT_DELAY_CYCLES and REPEAT_RATE_CYCLES parameters SHALL be ignored.

Verification
Bench parameters: NUM_KEYS=4, DEBOUNCE_CYCLES=8, KEY_ACTIVE_LOW=1. Cycle numbers below are relative to the stimulus edge.
REQ-029 Clean press: key_in[1] goes 1->0 at cycle 0 -> key_level[1]=1 and key_press[1] single pulse at cycle 10; key_code=1, key_valid=1 at cycle 11.
REQ-030 Bounce: key_in[0] low for 5 cycles, then high -> key_level, key_press and key_valid stay 0 throughout.
REQ-031 Simultaneous press: key_in[3] and key_in[2] fall at cycle 0 -> both key_press pulse at cycle 10; key_code=2 at cycle 11.
REQ-032 Release: held key_in[1] goes 0->1 at cycle 0 -> key_release[1] pulse and key_level[1]=0 at cycle 10; key_valid=0 at cycle 11.
REQ-033 Reset mid-count: rst=1 at cycle 5 of a press count, released at cycle 6 with the key still held -> no pulse before cycle 6+10=16, then key_press at cycle 16.
REQ-034 Auto-repeat (KEY_AUTO_REPEAT_EN defined, DELAY=20, RATE=6): key held from cycle 0 -> key_press pulses at cycles 10, 30, 36, 42, ...; pulses stop once key_level falls.
